// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : multiply/divide unit owning the HI/LO register pair
//
// Accepts a single-cycle start with an operation code, holds busy for a fixed
// number of cycles, then commits the 64-bit result to HI/LO. Also services
// MTHI/MTLO writes in IDLE. A same-cycle interrupt/exception request (req)
// drops start and MTHI/MTLO writes.
//
// The result is computed combinationally from the operands at start and parked
// in res_hi/res_lo. The busy window only models the issue latency seen by the
// pipeline.
//
// Optional feature macro: MDU_MADD_EN
//   defined   : md_op 101/110 run MADD/MADDU (accumulate into HI/LO)
//   undefined : md_op 101/110 are no-ops and no accumulate adder is built
//
// Parameters
//   MUL_CYCLES  busy cycles for MULT/MULTU/MADD/MADDU
//   DIV_CYCLES  busy cycles for DIV/DIVU
//
// Ports
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous active-high reset
//   start   in   1   begin a multi-cycle operation
//   md_op   in   3   001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MADD, 110 MADDU
//   a       in  32   rs operand
//   b       in  32   rt operand
//   we_hi   in   1   MTHI write enable
//   we_lo   in   1   MTLO write enable
//   wdata   in  32   MTHI/MTLO data
//   req     in   1   interrupt/exception taken this cycle
//   busy    out  1   operation in progress
//   hi      out 32   HI register
//   lo      out 32   LO register
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state | meaning
    // IDLE  | no operation pending, MTHI/MTLO and start accepted
    // RUN   | operation counting down, commits result when cnt reaches 1
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MADD  = 3'b101;
    localparam logic [2:0] OP_MADDU = 3'b110;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      res_hi_q;
    logic [31:0]      res_lo_q;

    logic             op_valid;
    logic             op_is_div;
    logic             mul_signed;
    logic             div_signed;
    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic [63:0]      product;
    logic             neg_a;
    logic             neg_b;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic [31:0]      divisor;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic [31:0]      res_hi_d;
    logic [31:0]      res_lo_d;
    logic             start_go;
    logic             mt_go;

    // Operation decode
    always_comb begin
        op_valid   = 1'b0;
        op_is_div  = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
        case (md_op)
            OP_MULT:  begin op_valid = 1'b1; mul_signed = 1'b1; end
            OP_MULTU: begin op_valid = 1'b1; end
            OP_DIV:   begin op_valid = 1'b1; op_is_div = 1'b1; div_signed = 1'b1; end
            OP_DIVU:  begin op_valid = 1'b1; op_is_div = 1'b1; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin op_valid = 1'b1; mul_signed = 1'b1; end
            OP_MADDU: begin op_valid = 1'b1; end
`endif
            default:  begin op_valid = 1'b0; end
        endcase
    end

    // One 64-bit multiplier serves both signednesses: the low 64 bits of the
    // product of sign-extended operands equal the signed 32x32 product.
    always_comb begin
        mul_a   = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
        mul_b   = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
        product = mul_a * mul_b;
    end

    // Signed divide runs on magnitudes through the unsigned divider. This also
    // yields -2^31 / -1 = 0x80000000 rem 0 with no special casing, since the
    // magnitude 0x80000000 is representable unsigned.
    always_comb begin
        neg_a   = div_signed & a[31];
        neg_b   = div_signed & b[31];
        mag_a   = neg_a ? (~a + 32'd1) : a;
        mag_b   = neg_b ? (~b + 32'd1) : b;
        divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        quot    = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        rem     = neg_a ? (~r_mag + 32'd1) : r_mag;
    end

    // Pending result selection
    always_comb begin
        res_hi_d = hi_q;
        res_lo_d = lo_q;
        if (op_is_div) begin
            // Divide by zero keeps HI/LO as they are at commit time.
            if (b != 32'd0) begin
                res_hi_d = rem;
                res_lo_d = quot;
            end
        end else begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    {res_hi_d, res_lo_d} = product;
                end
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU: begin
                    {res_hi_d, res_lo_d} = {hi_q, lo_q} + product;
                end
`endif
                default: begin
                    res_hi_d = hi_q;
                    res_lo_d = lo_q;
                end
            endcase
        end
    end

    assign start_go = (state_q == IDLE) & start & ~req & op_valid;
    // Any start in the cycle drops MTHI/MTLO, even a no-op start.
    assign mt_go    = (state_q == IDLE) & ~start & ~req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_go) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= op_is_div ? DIV_LOAD : MUL_LOAD;
                        res_hi_q <= res_hi_d;
                        res_lo_q <= res_lo_d;
                    end else if (mt_go) begin
                        if (we_hi) hi_q <= wdata;
                        if (we_lo) lo_q <= wdata;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        hi_q    <= res_hi_q;
                        lo_q    <= res_lo_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wdata;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .req   (req),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start and counts busy cycles (bounded).
    task automatic do_op(input logic [2:0] op, input logic [31:0] ra,
                         input logic [31:0] rb, output int cyc);
        md_op = op; a = ra; b = rb; start = 1'b1;
        tick();
        start = 1'b0; md_op = 3'b000;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
        we_hi = wh; we_lo = wl; wdata = d;
        tick();
        we_hi = 1'b0; we_lo = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    endtask

    task automatic test_mult();
        int cyc;
        do_op(3'b001, 32'hFFFFFFFE, 32'd3, cyc);
        checks++; if (cyc != MUL_N) begin errors++; $display("FAIL mult_cycles: got %0d want %0d", cyc, MUL_N); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi, lo); end
        do_op(3'b001, 32'h80000000, 32'h80000000, cyc);
        checks++; if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
            errors++; $display("FAIL mult_minmin: got %h_%h want 40000000_00000000", hi, lo); end
    endtask

    task automatic test_div();
        int cyc;
        do_op(3'b011, 32'hFFFFFFF9, 32'd2, cyc);
        checks++; if (cyc != DIV_N) begin errors++; $display("FAIL div_cycles: got %0d want %0d", cyc, DIV_N); end
        checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL div_neg7_2: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo); end
        do_op(3'b100, 32'hFFFFFFF9, 32'd2, cyc);
        checks++; if (lo !== 32'h7FFFFFFC || hi !== 32'h00000001) begin
            errors++; $display("FAIL divu: got hi=%h lo=%h want hi=00000001 lo=7ffffffc", hi, lo); end
        do_op(3'b011, 32'd7, 32'hFFFFFFFE, cyc);
        checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
            errors++; $display("FAIL div_7_neg2: got hi=%h lo=%h want hi=00000001 lo=fffffffd", hi, lo); end
        do_op(3'b011, 32'h80000000, 32'hFFFFFFFF, cyc);
        checks++; if (lo !== 32'h80000000 || hi !== 32'h00000000) begin
            errors++; $display("FAIL div_ovf: got hi=%h lo=%h want hi=00000000 lo=80000000", hi, lo); end
    endtask

    task automatic test_div_zero();
        int cyc;
        mt_write(1'b1, 1'b0, 32'h11);
        mt_write(1'b0, 1'b1, 32'h22);
        do_op(3'b100, 32'h1234, 32'd0, cyc);
        checks++; if (cyc != DIV_N) begin errors++; $display("FAIL divz_cycles: got %0d want %0d", cyc, DIV_N); end
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin
            errors++; $display("FAIL divz_keep: got hi=%h lo=%h want hi=00000011 lo=00000022", hi, lo); end
    endtask

    task automatic test_mthi_mtlo();
        mt_write(1'b1, 1'b0, 32'hABCD);
        checks++; if (hi !== 32'hABCD || lo !== 32'h22) begin
            errors++; $display("FAIL mthi: got hi=%h lo=%h want hi=0000abcd lo=00000022", hi, lo); end
        mt_write(1'b1, 1'b1, 32'h5A5A);
        checks++; if (hi !== 32'h5A5A || lo !== 32'h5A5A) begin
            errors++; $display("FAIL mt_both: got hi=%h lo=%h want 00005a5a both", hi, lo); end
    endtask

    task automatic test_we_during_run();
        int n;
        md_op = 3'b010; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        we_lo = 1'b1; wdata = 32'hDEAD;
        tick();
        we_lo = 1'b0;
        checks++; if (lo !== 32'h5A5A) begin errors++; $display("FAIL mtlo_in_run: got %h want 00005a5a", lo); end
        n = 0;
        while (busy === 1'b1 && n < 200) begin n++; tick(); end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin
            errors++; $display("FAIL run_result: got hi=%h lo=%h want hi=00000000 lo=00000006", hi, lo); end
    endtask

    task automatic test_start_wins();
        md_op = 3'b010; a = 32'd4; b = 32'd5; start = 1'b1;
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hCAFE;
        tick();
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        checks++; if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd6) begin
            errors++; $display("FAIL start_wins_edge: got busy=%0b hi=%h lo=%h want 1 00000000 00000006", busy, hi, lo); end
        for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
        checks++; if (hi !== 32'd0 || lo !== 32'd20) begin
            errors++; $display("FAIL start_wins_res: got hi=%h lo=%h want hi=00000000 lo=00000014", hi, lo); end
    endtask

    task automatic test_req();
        int n;
        md_op = 3'b010; a = 32'd2; b = 32'd3; start = 1'b1; req = 1'b1;
        tick();
        start = 1'b0; req = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd20) begin
            errors++; $display("FAIL req_start: got busy=%0b hi=%h lo=%h want 0 00000000 00000014", busy, hi, lo); end
        we_hi = 1'b1; wdata = 32'h77; req = 1'b1;
        tick();
        we_hi = 1'b0; req = 1'b0;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL req_mthi: got %h want 00000000", hi); end
        md_op = 3'b010; a = 32'd7; b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin n++; tick(); end
        checks++; if (hi !== 32'd0 || lo !== 32'd42) begin
            errors++; $display("FAIL req_midrun: got hi=%h lo=%h want hi=00000000 lo=0000002a", hi, lo); end
    endtask

    task automatic test_noop();
        int cyc;
        do_op(3'b000, 32'd9, 32'd9, cyc);
        checks++; if (cyc != 0 || lo !== 32'd42) begin
            errors++; $display("FAIL noop000: got cyc=%0d lo=%h want 0 0000002a", cyc, lo); end
        do_op(3'b111, 32'd9, 32'd9, cyc);
        checks++; if (cyc != 0 || lo !== 32'd42) begin
            errors++; $display("FAIL noop111: got cyc=%0d lo=%h want 0 0000002a", cyc, lo); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_op(3'b010, 32'd10, 32'd10, cyc);
        do_op(3'b100, 32'd100, 32'd7, cyc);
        checks++; if (cyc != DIV_N || hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL back_to_back: got cyc=%0d hi=%h lo=%h want %0d 00000002 0000000e", cyc, hi, lo, DIV_N); end
    endtask

    task automatic test_reset_mid_run();
        mt_write(1'b1, 1'b0, 32'h55);
        md_op = 3'b001; a = 32'hFFFFFFFE; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_midrun: got busy=%0b hi=%h lo=%h want 0 0 0", busy, hi, lo); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_nocommit: got busy=%0b hi=%h lo=%h want 0 0 0", busy, hi, lo); end
    endtask

    task automatic test_madd();
        int cyc;
        mt_write(1'b1, 1'b0, 32'd0);
        mt_write(1'b0, 1'b1, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        do_op(3'b110, 32'd1, 32'd1, cyc);
        checks++; if (cyc != MUL_N || hi !== 32'd1 || lo !== 32'd0) begin
            errors++; $display("FAIL maddu: got cyc=%0d hi=%h lo=%h want %0d 00000001 00000000", cyc, hi, lo, MUL_N); end
        do_op(3'b101, 32'hFFFFFFFF, 32'd1, cyc);
        checks++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL madd: got hi=%h lo=%h want 00000000 ffffffff", hi, lo); end
`else
        do_op(3'b110, 32'd1, 32'd1, cyc);
        checks++; if (cyc != 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL maddu_off: got cyc=%0d hi=%h lo=%h want 0 00000000 ffffffff", cyc, hi, lo); end
        do_op(3'b101, 32'd1, 32'd1, cyc);
        checks++; if (cyc != 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL madd_off: got cyc=%0d hi=%h lo=%h want 0 00000000 ffffffff", cyc, hi, lo); end
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'b000; a = 32'd0; b = 32'd0;
        we_hi = 1'b0; we_lo = 1'b0; wdata = 32'd0; req = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_we_during_run();
        test_start_wins();
        test_req();
        test_noop();
        test_back_to_back();
        test_reset_mid_run();
        test_madd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
